// File: rtl/mem_reset_pkg.sv
// Shared types for the DDR reset sequencer: channel state encoding, retry width,
// and the output flags each state drives.
package mem_reset_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_HOLD,
        ST_WAIT_CAL,
        ST_OK,
        ST_FAIL
    } mem_rst_state_t;

    localparam int RETRY_W = 4;

    typedef struct packed {
        logic mem_reset;
        logic mem_ok;
        logic mem_fail;
    } chan_flags_t;

    function automatic chan_flags_t flags_of(mem_rst_state_t s);
        chan_flags_t f;
        f = '{mem_reset: 1'b1, mem_ok: 1'b0, mem_fail: 1'b0};
        case (s)
            ST_WAIT_CAL: f.mem_reset = 1'b0;
            ST_OK: begin
                f.mem_reset = 1'b0;
                f.mem_ok    = 1'b1;
            end
            ST_FAIL: f.mem_fail = 1'b1;
            default: ;
        endcase
        return f;
    endfunction

    // A one-cycle period still needs a 1-bit counter.
    function automatic int cnt_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_reset_channel.sv
// One memory channel: synchronizer bank for its asynchronous status inputs plus the
// reset / hold / calibration-supervision state machine.
//
// state    | meaning
// RESET    | controller held in reset until clock_ok and no sys_reset
// HOLD     | inputs qualified, counting out the reset hold time
// WAIT_CAL | reset released, waiting for lock + calibration under timeout
// OK       | locked and calibrated
// FAIL     | retries exhausted; left only via sys_reset or sys_reset_n
module mem_reset_channel
    import mem_reset_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int CAL_TIMEOUT = 1000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic               clock,
    input  logic               sys_reset_n,
    input  logic               sys_reset_sync,
    input  logic               clock_ok,
    input  logic               mmcm_locked,
    input  logic               calib_complete,
    output logic               mem_reset,
    output logic               mem_ok,
    output logic               mem_fail,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int CAL_W  = cnt_width(CAL_TIMEOUT);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CAL_W-1:0]   CAL_LAST  = CAL_W'(CAL_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    (* ASYNC_REG = "TRUE" *) logic [2:0] sync_q [SYNC_STAGES];

    logic clock_ok_s;
    logic locked_s;
    logic calib_s;
    logic ready_s;

    mem_rst_state_t    state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CAL_W-1:0]  cal_cnt;

    always_ff @(posedge clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {clock_ok, mmcm_locked, calib_complete};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {clock_ok_s, locked_s, calib_s} = sync_q[SYNC_STAGES-1];
    assign ready_s = locked_s & calib_s;

    // Abort branches sit ahead of the state case so they beat success or timeout.
    always_ff @(posedge clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state       <= ST_RESET;
            hold_cnt    <= '0;
            cal_cnt     <= '0;
            retry_count <= '0;
            {mem_reset, mem_ok, mem_fail} <= flags_of(ST_RESET);
        end else if (sys_reset_sync) begin
            state       <= ST_RESET;
            retry_count <= '0;
            {mem_reset, mem_ok, mem_fail} <= flags_of(ST_RESET);
        end else if (!clock_ok_s && state != ST_FAIL) begin
            state <= ST_RESET;
            {mem_reset, mem_ok, mem_fail} <= flags_of(ST_RESET);
        end else begin
            unique case (state)
                ST_RESET: begin
                    state    <= ST_HOLD;
                    hold_cnt <= '0;
                    {mem_reset, mem_ok, mem_fail} <= flags_of(ST_HOLD);
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state   <= ST_WAIT_CAL;
                        cal_cnt <= '0;
                        {mem_reset, mem_ok, mem_fail} <= flags_of(ST_WAIT_CAL);
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_WAIT_CAL: begin
                    if (ready_s) begin
                        state <= ST_OK;
                        {mem_reset, mem_ok, mem_fail} <= flags_of(ST_OK);
                    end else if (cal_cnt == CAL_LAST) begin
                        if (retry_count < RETRY_MAX) begin
                            retry_count <= retry_count + 1'b1;
                            state       <= ST_RESET;
                            {mem_reset, mem_ok, mem_fail} <= flags_of(ST_RESET);
                        end else begin
                            state <= ST_FAIL;
                            {mem_reset, mem_ok, mem_fail} <= flags_of(ST_FAIL);
                        end
                    end else begin
                        cal_cnt <= cal_cnt + 1'b1;
                    end
                end
                ST_OK: begin
                    if (!ready_s) begin
                        state   <= ST_WAIT_CAL;
                        cal_cnt <= '0;
                        {mem_reset, mem_ok, mem_fail} <= flags_of(ST_WAIT_CAL);
                    end
                end
                ST_FAIL: ;
                default: begin
                    state <= ST_RESET;
                    {mem_reset, mem_ok, mem_fail} <= flags_of(ST_RESET);
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_reset_sequencer.sv
// Multi-channel DDR reset sequencer: shared sys_reset synchronizer, one sequencing
// channel per memory controller, and a registered aggregate ready.
module mem_reset_sequencer
    import mem_reset_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int SYNC_STAGES = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int CAL_TIMEOUT = 1000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic                          clock,
    input  logic                          sys_reset_n,
    input  logic                          sys_reset,
    input  logic [CHANNELS-1:0]           clock_ok,
    input  logic [CHANNELS-1:0]           mmcm_locked,
    input  logic [CHANNELS-1:0]           calib_complete,
    output logic [CHANNELS-1:0]           mem_reset,
    output logic [CHANNELS-1:0]           mem_ok,
    output logic [CHANNELS-1:0]           mem_fail,
    output logic                          all_ok,
    output logic [RETRY_W*CHANNELS-1:0]   retry_count
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sys_reset_q;
    logic sys_reset_sync;

    always_ff @(posedge clock or negedge sys_reset_n) begin
        if (!sys_reset_n) sys_reset_q <= '0;
        else              sys_reset_q <= {sys_reset_q[SYNC_STAGES-2:0], sys_reset};
    end

    assign sys_reset_sync = sys_reset_q[SYNC_STAGES-1];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        mem_reset_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .HOLD_CYCLES (HOLD_CYCLES),
            .CAL_TIMEOUT (CAL_TIMEOUT),
            .MAX_RETRY   (MAX_RETRY)
        ) u_chan (
            .clock          (clock),
            .sys_reset_n    (sys_reset_n),
            .sys_reset_sync (sys_reset_sync),
            .clock_ok       (clock_ok[i]),
            .mmcm_locked    (mmcm_locked[i]),
            .calib_complete (calib_complete[i]),
            .mem_reset      (mem_reset[i]),
            .mem_ok         (mem_ok[i]),
            .mem_fail       (mem_fail[i]),
            .retry_count    (retry_count[RETRY_W*i +: RETRY_W])
        );
    end

    always_ff @(posedge clock or negedge sys_reset_n) begin
        if (!sys_reset_n) all_ok <= 1'b0;
        else              all_ok <= &mem_ok;
    end

endmodule

// File: tb/tb_mem_reset_sequencer.sv
// Bench for mem_reset_sequencer: directed scenarios with cycle-exact expectations,
// then randomized input activity checked against a timestamp-based reference model.
module tb_mem_reset_sequencer;

    localparam int CH   = 2;
    localparam int SYNC = 3;
    localparam int HOLD = 16;
    localparam int CAL  = 100;
    localparam int MAXR = 2;

    localparam int P_RESET = 0, P_HOLD = 1, P_WAIT = 2, P_OK = 3, P_FAIL = 4;

    logic          clock = 1'b0;
    logic          sys_reset_n = 1'b1;
    logic          sys_reset = 1'b0;
    logic [CH-1:0] clock_ok = '0;
    logic [CH-1:0] mmcm_locked = '0;
    logic [CH-1:0] calib_complete = '0;
    logic [CH-1:0] mem_reset, mem_ok, mem_fail;
    logic          all_ok;
    logic [4*CH-1:0] retry_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int valid_from = 1;

    // Reference model: per-channel phase, phase start edge, retries used.
    int ph [CH];
    int t0 [CH];
    int rc [CH];
    logic          h_sr [8];
    logic [CH-1:0] h_ck [8];
    logic [CH-1:0] h_lk [8];
    logic [CH-1:0] h_cb [8];
    logic [CH-1:0] exp_rst, exp_ok, exp_fail;
    logic          exp_all;
    logic [4*CH-1:0] exp_rc;

    mem_reset_sequencer #(
        .CHANNELS    (CH),
        .SYNC_STAGES (SYNC),
        .HOLD_CYCLES (HOLD),
        .CAL_TIMEOUT (CAL),
        .MAX_RETRY   (MAXR)
    ) dut (
        .clock          (clock),
        .sys_reset_n    (sys_reset_n),
        .sys_reset      (sys_reset),
        .clock_ok       (clock_ok),
        .mmcm_locked    (mmcm_locked),
        .calib_complete (calib_complete),
        .mem_reset      (mem_reset),
        .mem_ok         (mem_ok),
        .mem_fail       (mem_fail),
        .all_ok         (all_ok),
        .retry_count    (retry_count)
    );

    always #5 clock = ~clock;

    task automatic model_outputs();
        for (int c = 0; c < CH; c++) begin
            exp_rst[c]  = (ph[c] == P_RESET) || (ph[c] == P_HOLD) || (ph[c] == P_FAIL);
            exp_ok[c]   = (ph[c] == P_OK);
            exp_fail[c] = (ph[c] == P_FAIL);
            exp_rc[4*c +: 4] = 4'(rc[c]);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            ph[c] = P_RESET;
            t0[c] = 0;
            rc[c] = 0;
        end
        exp_all = 1'b0;
        model_outputs();
    endtask

    // An input sampled at edge k is acted on at edge k+SYNC.
    task automatic model_edge();
        int   k, s, d;
        logic e_sr, ck, lk, cb, prev_all;
        logic [CH-1:0] e_ck, e_lk, e_cb;
        k = cyc;
        s = k % 8;
        h_sr[s] = sys_reset;
        h_ck[s] = clock_ok;
        h_lk[s] = mmcm_locked;
        h_cb[s] = calib_complete;
        if (!sys_reset_n) begin
            model_reset();
            valid_from = k + 1;
            return;
        end
        e_sr = 1'b0; e_ck = '0; e_lk = '0; e_cb = '0;
        if (k - SYNC >= valid_from) begin
            d = (k - SYNC) % 8;
            e_sr = h_sr[d]; e_ck = h_ck[d]; e_lk = h_lk[d]; e_cb = h_cb[d];
        end
        prev_all = &exp_ok;
        for (int c = 0; c < CH; c++) begin
            ck = e_ck[c]; lk = e_lk[c]; cb = e_cb[c];
            if (e_sr) begin
                ph[c] = P_RESET;
                rc[c] = 0;
            end else if (!ck && ph[c] != P_FAIL) begin
                ph[c] = P_RESET;
            end else begin
                case (ph[c])
                    P_RESET: begin ph[c] = P_HOLD; t0[c] = k; end
                    P_HOLD:  if (k - t0[c] == HOLD) begin ph[c] = P_WAIT; t0[c] = k; end
                    P_WAIT: begin
                        if (lk && cb) ph[c] = P_OK;
                        else if (k - t0[c] == CAL) begin
                            if (rc[c] < MAXR) begin rc[c]++; ph[c] = P_RESET; end
                            else ph[c] = P_FAIL;
                        end
                    end
                    P_OK:    if (!(lk && cb)) begin ph[c] = P_WAIT; t0[c] = k; end
                    default: ;
                endcase
            end
        end
        model_outputs();
        exp_all = prev_all;
    endtask

    task automatic step();
        @(posedge clock);
        cyc++;
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #1 sys_reset_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({mem_reset, mem_ok, mem_fail, all_ok, retry_count} !== {2'b11, 2'b00, 2'b00, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_async got rst=%b ok=%b fail=%b all=%b retry=%h want 11 00 00 0 00",
                     mem_reset, mem_ok, mem_fail, all_ok, retry_count);
        end
        clock_ok = '1; mmcm_locked = '1; calib_complete = '1;
        for (int i = 0; i < 6; i++) step();
        n_tests++;
        if ({mem_reset, mem_ok, mem_fail, all_ok, retry_count} !== {2'b11, 2'b00, 2'b00, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_held got rst=%b ok=%b fail=%b all=%b retry=%h want 11 00 00 0 00",
                     mem_reset, mem_ok, mem_fail, all_ok, retry_count);
        end
        clock_ok = '0; mmcm_locked = '0; calib_complete = '0;
    endtask

    task automatic test_power_up();
        int base, t;
        #1 sys_reset_n = 1'b1;
        base = cyc;
        for (int i = 1; i <= 60; i++) begin
            step();
            t = cyc - base;
            if (t == 29) begin n_tests++; if (mem_reset[0] !== 1'b1) begin n_fail++; $display("FAIL pwr_rst0_before t=%0d got %b want 1", t, mem_reset[0]); end end
            if (t == 30) begin n_tests++; if (mem_reset[0] !== 1'b0) begin n_fail++; $display("FAIL pwr_rst0_fall t=%0d got %b want 0", t, mem_reset[0]); end end
            if (t == 31) begin n_tests++; if (mem_reset[1] !== 1'b1) begin n_fail++; $display("FAIL pwr_rst1_before t=%0d got %b want 1", t, mem_reset[1]); end end
            if (t == 32) begin n_tests++; if (mem_reset[1] !== 1'b0) begin n_fail++; $display("FAIL pwr_rst1_fall t=%0d got %b want 0", t, mem_reset[1]); end end
            if (t == 43) begin n_tests++; if (mem_ok[0] !== 1'b0) begin n_fail++; $display("FAIL pwr_ok0_before t=%0d got %b want 0", t, mem_ok[0]); end end
            if (t == 44) begin n_tests++; if (mem_ok[0] !== 1'b1) begin n_fail++; $display("FAIL pwr_ok0_rise t=%0d got %b want 1", t, mem_ok[0]); end end
            if (t == 54) begin n_tests++; if ({mem_ok[1], all_ok} !== 2'b10) begin n_fail++; $display("FAIL pwr_ok1_rise t=%0d got ok1,all=%b want 10", t, {mem_ok[1], all_ok}); end end
            if (t == 55) begin n_tests++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL pwr_all_ok t=%0d got %b want 1", t, all_ok); end end
            if (t == 10) clock_ok[0] = 1'b1;
            if (t == 12) clock_ok[1] = 1'b1;
            if (t == 40) begin mmcm_locked[0] = 1'b1; calib_complete[0] = 1'b1; end
            if (t == 50) begin mmcm_locked[1] = 1'b1; calib_complete[1] = 1'b1; end
        end
    endtask

    task automatic test_cal_loss();
        int base, t;
        base = cyc;
        calib_complete[0] = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            step();
            t = cyc - base;
            if (t == 3)  begin n_tests++; if (mem_ok[0] !== 1'b1) begin n_fail++; $display("FAIL calloss_ok_before t=%0d got %b want 1", t, mem_ok[0]); end end
            if (t == 4)  begin n_tests++; if ({mem_ok[0], mem_reset[0]} !== 2'b00) begin n_fail++; $display("FAIL calloss_drop t=%0d got ok,rst=%b want 00", t, {mem_ok[0], mem_reset[0]}); end end
            if (t == 5)  begin n_tests++; if (all_ok !== 1'b0) begin n_fail++; $display("FAIL calloss_all t=%0d got %b want 0", t, all_ok); end end
            if (t == 13) begin n_tests++; if (mem_ok[0] !== 1'b0) begin n_fail++; $display("FAIL calloss_rec_before t=%0d got %b want 0", t, mem_ok[0]); end end
            if (t == 14) begin n_tests++; if (mem_ok[0] !== 1'b1) begin n_fail++; $display("FAIL calloss_recover t=%0d got %b want 1", t, mem_ok[0]); end end
            if (t == 20) begin n_tests++; if (retry_count !== 8'h00) begin n_fail++; $display("FAIL calloss_retry t=%0d got %h want 00", t, retry_count); end end
            if (t == 10) calib_complete[0] = 1'b1;
        end
    endtask

    task automatic test_clock_loss_hold();
        int base, t;
        base = cyc;
        clock_ok[0] = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            step();
            t = cyc - base;
            if (t == 4)  begin n_tests++; if ({mem_reset[0], mem_ok[0]} !== 2'b10) begin n_fail++; $display("FAIL clkloss_reset t=%0d got rst,ok=%b want 10", t, {mem_reset[0], mem_ok[0]}); end end
            if (t == 30) begin n_tests++; if (mem_reset[0] !== 1'b1) begin n_fail++; $display("FAIL clkloss_no_early_release t=%0d got %b want 1", t, mem_reset[0]); end end
            if (t == 44) begin n_tests++; if (mem_reset[0] !== 1'b1) begin n_fail++; $display("FAIL clkloss_full_hold t=%0d got %b want 1", t, mem_reset[0]); end end
            if (t == 45) begin n_tests++; if (mem_reset[0] !== 1'b0) begin n_fail++; $display("FAIL clkloss_release t=%0d got %b want 0", t, mem_reset[0]); end end
            if (t == 46) begin n_tests++; if ({mem_ok[0], retry_count} !== 9'h100) begin n_fail++; $display("FAIL clkloss_ok t=%0d got ok=%b retry=%h want 1 00", t, mem_ok[0], retry_count); end end
            if (t == 10) clock_ok[0] = 1'b1;
            if (t == 16) clock_ok[0] = 1'b0;
            if (t == 25) clock_ok[0] = 1'b1;
        end
    endtask

    task automatic test_timeout_retry();
        int base, t;
        base = cyc;
        sys_reset = 1'b1;
        calib_complete[1] = 1'b0;
        for (int i = 1; i <= 450; i++) begin
            step();
            t = cyc - base;
            if (t == 121) begin n_tests++; if ({retry_count[7:4], mem_reset[1]} !== 5'b0000_0) begin n_fail++; $display("FAIL to_before1 t=%0d got retry=%0d rst=%b want 0 0", t, retry_count[7:4], mem_reset[1]); end end
            if (t == 122) begin n_tests++; if ({retry_count[7:4], mem_reset[1]} !== 5'b0001_1) begin n_fail++; $display("FAIL to_retry1 t=%0d got retry=%0d rst=%b want 1 1", t, retry_count[7:4], mem_reset[1]); end end
            if (t == 238) begin n_tests++; if (retry_count[7:4] !== 4'd1) begin n_fail++; $display("FAIL to_before2 t=%0d got %0d want 1", t, retry_count[7:4]); end end
            if (t == 239) begin n_tests++; if (retry_count[7:4] !== 4'd2) begin n_fail++; $display("FAIL to_retry2 t=%0d got %0d want 2", t, retry_count[7:4]); end end
            if (t == 355) begin n_tests++; if ({mem_fail[1], mem_reset[1]} !== 2'b00) begin n_fail++; $display("FAIL to_before_fail t=%0d got fail,rst=%b want 00", t, {mem_fail[1], mem_reset[1]}); end end
            if (t == 356) begin n_tests++; if ({mem_fail[1], mem_reset[1], retry_count[7:4]} !== 6'b11_0010) begin n_fail++; $display("FAIL to_fail t=%0d got fail=%b rst=%b retry=%0d want 1 1 2", t, mem_fail[1], mem_reset[1], retry_count[7:4]); end end
            if (t == 377) begin n_tests++; if (mem_fail[1] !== 1'b1) begin n_fail++; $display("FAIL to_fail_clkloss t=%0d got %b want 1", t, mem_fail[1]); end end
            if (t == 400) begin n_tests++; if ({mem_fail, mem_reset[1], mem_ok[0], all_ok} !== 5'b10_1_1_0) begin n_fail++; $display("FAIL to_fail_sticky t=%0d got fail=%b rst1=%b ok0=%b all=%b want 10 1 1 0", t, mem_fail, mem_reset[1], mem_ok[0], all_ok); end end
            if (t == 413) begin n_tests++; if (mem_fail[1] !== 1'b1) begin n_fail++; $display("FAIL to_sysrst_before t=%0d got %b want 1", t, mem_fail[1]); end end
            if (t == 414) begin n_tests++; if ({mem_fail[1], retry_count} !== 9'h000) begin n_fail++; $display("FAIL to_sysrst_clear t=%0d got fail=%b retry=%h want 0 00", t, mem_fail[1], retry_count); end end
            if (t == 2)   sys_reset = 1'b0;
            if (t == 370) clock_ok[1] = 1'b0;
            if (t == 380) clock_ok[1] = 1'b1;
            if (t == 410) sys_reset = 1'b1;
            if (t == 412) sys_reset = 1'b0;
            if (t == 420) calib_complete[1] = 1'b1;
        end
    endtask

    task automatic test_simultaneous();
        int base, t;
        base = cyc;
        calib_complete[0] = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            step();
            t = cyc - base;
            if (t == 13) begin n_tests++; if ({mem_reset[0], mem_ok[0]} !== 2'b00) begin n_fail++; $display("FAIL sim_waitcal t=%0d got rst,ok=%b want 00", t, {mem_reset[0], mem_ok[0]}); end end
            if (t == 14) begin n_tests++; if ({mem_reset[0], mem_ok[0]} !== 2'b10) begin n_fail++; $display("FAIL sim_abort_wins t=%0d got rst,ok=%b want 10", t, {mem_reset[0], mem_ok[0]}); end end
            if (t == 16) begin n_tests++; if (mem_ok[0] !== 1'b0) begin n_fail++; $display("FAIL sim_ok_stays_low t=%0d got %b want 0", t, mem_ok[0]); end end
            if (t == 32) begin n_tests++; if ({mem_reset[0], mem_ok[0]} !== 2'b00) begin n_fail++; $display("FAIL sim_rehold t=%0d got rst,ok=%b want 00", t, {mem_reset[0], mem_ok[0]}); end end
            if (t == 33) begin n_tests++; if (mem_ok[0] !== 1'b1) begin n_fail++; $display("FAIL sim_recover t=%0d got %b want 1", t, mem_ok[0]); end end
            if (t == 10) begin sys_reset = 1'b1; calib_complete[0] = 1'b1; end
            if (t == 12) sys_reset = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        int base, t;
        base = cyc;
        calib_complete[1] = 1'b0;
        for (int i = 1; i <= 128; i++) begin
            step();
            t = cyc - base;
            if (t == 118) calib_complete[0] = 1'b0;
        end
        n_tests++;
        if ({retry_count[7:4], mem_reset[0], mem_ok[0]} !== 6'b0001_00) begin
            n_fail++;
            $display("FAIL arst_precond got retry1=%0d rst0=%b ok0=%b want 1 0 0", retry_count[7:4], mem_reset[0], mem_ok[0]);
        end
        #2 sys_reset_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({mem_reset, mem_ok, mem_fail, all_ok, retry_count} !== {2'b11, 2'b00, 2'b00, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL arst_immediate got rst=%b ok=%b fail=%b all=%b retry=%h want 11 00 00 0 00",
                     mem_reset, mem_ok, mem_fail, all_ok, retry_count);
        end
        calib_complete = '1;
        for (int i = 0; i < 3; i++) step();
        n_tests++;
        if ({mem_reset, mem_ok, mem_fail, all_ok, retry_count} !== {2'b11, 2'b00, 2'b00, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL arst_held got rst=%b ok=%b fail=%b all=%b retry=%h want 11 00 00 0 00",
                     mem_reset, mem_ok, mem_fail, all_ok, retry_count);
        end
        #2 sys_reset_n = 1'b1;
    endtask

    task automatic test_random();
        int mode;
        for (int i = 0; i < 4500; i++) begin
            step();
            n_tests++;
            if ({mem_reset, mem_ok, mem_fail, all_ok, retry_count} !== {exp_rst, exp_ok, exp_fail, exp_all, exp_rc}) begin
                n_fail++;
                $display("FAIL random cyc=%0d rst=%b/%b ok=%b/%b fail=%b/%b all=%b/%b retry=%h/%h (got/want)",
                         cyc, mem_reset, exp_rst, mem_ok, exp_ok, mem_fail, exp_fail, all_ok, exp_all, retry_count, exp_rc);
            end
            mode = (i / 500) % 3;
            if (sys_reset) begin
                if ($urandom_range(2) == 0) sys_reset = 1'b0;
            end else if ($urandom_range(mode == 1 ? 1499 : 299) == 0) begin
                sys_reset = 1'b1;
            end
            for (int c = 0; c < CH; c++) begin
                if (clock_ok[c]) begin
                    if ($urandom_range(mode == 2 ? 40 : 299) == 0) clock_ok[c] = 1'b0;
                end else if ($urandom_range(7) == 0) clock_ok[c] = 1'b1;
                if (mmcm_locked[c]) begin
                    if ($urandom_range(mode == 2 ? 30 : 299) == 0) mmcm_locked[c] = 1'b0;
                end else if ($urandom_range(9) == 0) mmcm_locked[c] = 1'b1;
                if (calib_complete[c]) begin
                    if ($urandom_range(mode == 2 ? 15 : 99) == 0) calib_complete[c] = 1'b0;
                end else if ($urandom_range(mode == 1 ? 399 : 19) == 0) calib_complete[c] = 1'b1;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_power_up();
        test_cal_loss();
        test_clock_loss_hold();
        test_timeout_retry();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
